// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - burst-size encodings, FSM state type and beat-count helper
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_1  = 2'b00,
    SIZE_4  = 2'b01,
    SIZE_8  = 2'b10,
    SIZE_16 = 2'b11
  } access_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WBURST = 2'b01,
    RBURST = 2'b10
  } state_e;

  function automatic logic [4:0] beat_count(input logic [1:0] size);
    logic [4:0] n;
    case (size)
      SIZE_1:  n = 5'd1;
      SIZE_4:  n = 5'd4;
      SIZE_8:  n = 5'd8;
      default: n = 5'd16;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous RAM with registered, read-enabled output
module mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 262144,
  parameter int INDEX_BITS = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is never reset so contents survive an aborted burst.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Output register only loads on read beats, so it holds between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/burst_memory.sv
// rtl/burst_memory.sv - burst-capable word memory; BURST_MEMORY_ALIGN_CHECK_EN rejects misaligned requests
module burst_memory
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 262144,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            access_size,
  input  logic                  rw,
  input  logic                  enable,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  error
);

  localparam int IW = $clog2(DEPTH);

  state_e        state;
  logic [3:0]    beat;
  logic [3:0]    last_beat;
  logic [IW-1:0] cur_idx;
  logic [IW-1:0] req_idx;
  logic [IW-1:0] ram_addr;
  logic          accept;
  logic          misaligned;
  logic          go;
  logic          ram_we;
  logic          ram_re;

  assign busy   = (state != IDLE);
  assign accept = enable && !busy;

`ifdef BURST_MEMORY_ALIGN_CHECK_EN
  assign misaligned = (address[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign go = accept && !misaligned;

  // Truncation to IW bits gives the modulo-DEPTH wrap for free.
  assign req_idx  = IW'((address - START_ADDR) >> 2);
  assign ram_addr = busy ? cur_idx : req_idx;
  assign ram_we   = (go && !rw) || (state == WBURST);
  assign ram_re   = (go && rw) || (state == RBURST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      beat       <= '0;
      last_beat  <= '0;
      cur_idx    <= '0;
      data_valid <= 1'b0;
`ifdef BURST_MEMORY_ALIGN_CHECK_EN
      error      <= 1'b0;
`endif
    end else begin
      data_valid <= ram_re;
`ifdef BURST_MEMORY_ALIGN_CHECK_EN
      error      <= accept && misaligned;
`endif
      case (state)
        IDLE: begin
          if (go) begin
            // Beat 0 is serviced on the accept edge; the FSM handles beats 1..N-1.
            cur_idx   <= req_idx + IW'(1);
            beat      <= 4'd1;
            last_beat <= 4'(beat_count(access_size) - 5'd1);
            if (access_size != SIZE_1) begin
              state <= rw ? RBURST : WBURST;
            end
          end
        end
        WBURST, RBURST: begin
          cur_idx <= cur_idx + IW'(1);
          if (beat == last_beat) begin
            state <= IDLE;
            beat  <= '0;
          end else begin
            beat <= beat + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BURST_MEMORY_ALIGN_CHECK_EN
  assign error = 1'b0;
`endif

  mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .INDEX_BITS(IW)
  ) u_mem_array (
    .clock  (clock),
    .reset_n(reset_n),
    .we     (ram_we),
    .re     (ram_re),
    .addr   (ram_addr),
    .wdata  (data_in),
    .rdata  (data_out)
  );

endmodule

// File: tb/tb_burst_memory.sv
// tb/tb_burst_memory.sv - scoreboard bench for burst_memory (DEPTH=16 to exercise index wrap)
module tb_burst_memory;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [1:0]  access_size;
  logic        rw;
  logic        enable;
  logic        busy;
  logic [31:0] data_out;
  logic        data_valid;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model [16];
  logic [31:0] exp_v;

  burst_memory #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH     (16),
    .START_ADDR(32'h80020000)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .address    (address),
    .data_in    (data_in),
    .access_size(access_size),
    .rw         (rw),
    .enable     (enable),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int nbeats(input logic [1:0] sz);
    case (sz)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - 32'h80020000) >> 2) & 32'd15);
  endfunction

  // Scoreboard monitor: every presented read beat must match the next expected word.
  always @(negedge clock) begin
    if (reset_n && data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid data_out=%h required=no beat", data_out);
      end else begin
        exp_v = exp_q.pop_front();
        check("read_data", data_out, exp_v);
      end
    end
  end

  task automatic write_burst(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d0);
    int n, idx, bcnt;
    n = nbeats(sz);
    idx = widx(a);
    bcnt = 0;
    enable = 1'b1; rw = 1'b0; address = a; access_size = sz;
    for (int k = 0; k < n; k++) begin
      data_in = d0 + k;
      @(posedge clock); #1;
      enable = 1'b0;
      model[(idx + k) % 16] = d0 + k;
      if (busy) bcnt++;
    end
    check("wr_busy_cycles", bcnt, n - 1);
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [1:0] sz);
    int n, idx, bcnt, vcnt;
    n = nbeats(sz);
    idx = widx(a);
    bcnt = 0;
    vcnt = 0;
    enable = 1'b1; rw = 1'b1; address = a; access_size = sz;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model[(idx + k) % 16]);
      @(posedge clock); #1;
      enable = 1'b0;
      if (data_valid) vcnt++;
      if (busy) bcnt++;
    end
    check("rd_valid_cycles", vcnt, n);
    check("rd_busy_cycles", bcnt, n - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int vcnt;
    reset_n = 1'b0; enable = 1'b0; rw = 1'b0; address = '0; data_in = '0; access_size = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", data_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_error", error, 0);
    reset_n = 1'b1;

    // Single write then single read of the same word.
    write_burst(32'h80020000, 2'b00, 32'hDEADBEEF);
    read_burst(32'h80020000, 2'b00);
    check("single_rd_data", data_out, 32'hDEADBEEF);
    @(posedge clock); #1;
    check("single_valid_drop", data_valid, 0);
    check("single_hold", data_out, 32'hDEADBEEF);

    // 16-beat burst at 0x80020040 (word 16, which is word 0 at DEPTH=16).
    write_burst(32'h80020040, 2'b11, 32'd0);
    read_burst(32'h80020040, 2'b11);

    // 4-beat burst that wraps from word 15 to word 0.
    write_burst(32'h80020038, 2'b01, 32'hA);
    read_burst(32'h80020038, 2'b00);
    read_burst(32'h8002003C, 2'b00);
    read_burst(32'h80020000, 2'b00);
    read_burst(32'h80020004, 2'b00);
    check("wrap_last_word", data_out, 32'hD);

    // Requests while busy are ignored; a request right after busy falls is gapless.
    vcnt = 0;
    enable = 1'b1; rw = 1'b1; address = 32'h80020010; access_size = 2'b01;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'd4 + k);
      @(posedge clock); #1;
      if (data_valid) vcnt++;
      if (k < 3) begin
        enable = 1'b1; rw = 1'b0; address = 32'h80020020; access_size = 2'b00; data_in = 32'h99;
      end else begin
        enable = 1'b1; rw = 1'b1; address = 32'h80020020; access_size = 2'b00;
      end
    end
    check("b2b_busy_fell", busy, 0);
    exp_q.push_back(32'd8);
    @(posedge clock); #1;
    enable = 1'b0;
    if (data_valid) vcnt++;
    check("b2b_valid_gapless", vcnt, 5);
    @(posedge clock); #1;

    // Reset on beat 3 of an 8-beat write of 1..8 at word 0.
    enable = 1'b1; rw = 1'b0; address = 32'h80020000; access_size = 2'b10;
    for (int k = 0; k < 3; k++) begin
      data_in = k + 1;
      @(posedge clock); #1;
      enable = 1'b0;
      model[k] = k + 1;
    end
    data_in = 32'd4;
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", data_valid, 0);
    check("abort_data_out", data_out, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    check("model_word3_unchanged", model[3], 32'd3);
    read_burst(32'h80020000, 2'b01);

    // Misaligned request.
    enable = 1'b1; rw = 1'b0; address = 32'h80020002; access_size = 2'b00; data_in = 32'h12345678;
    @(posedge clock); #1;
    enable = 1'b0;
`ifdef BURST_MEMORY_ALIGN_CHECK_EN
    check("misalign_error", error, 1);
    check("misalign_busy", busy, 0);
    check("misalign_valid", data_valid, 0);
    @(posedge clock); #1;
    check("misalign_error_pulse", error, 0);
`else
    check("misalign_error_tied", error, 0);
    model[0] = 32'h12345678;
`endif
    read_burst(32'h80020000, 2'b00);

    repeat (3) @(posedge clock);
    #1;
    check("final_valid", data_valid, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
